// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM pipeline stage controller.
package mem_stage_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_res;
    logic [REG_W-1:0]  write_reg;
    logic              mem_to_reg;
    logic              reg_write;
    logic              write_reg_valid;
    logic              halt;
  } memwb_t;

  localparam int unsigned MEMWB_W = $bits(memwb_t);

  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/dff.sv
// Codebase register cell: synchronous active-high reset to zero.
module dff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/memwb_reg.sv
// MEM/WB output register bank; bubble_i replaces the load value with an empty slot.
module memwb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   bubble_i,
  input  memwb_t d_i,
  output memwb_t q_o
);

  memwb_t             memwb_d;
  logic [MEMWB_W-1:0] memwb_vec_d;
  logic [MEMWB_W-1:0] memwb_vec_q;

  always_comb begin
    memwb_d = bubble_i ? MEMWB_BUBBLE : d_i;
  end

  assign memwb_vec_d = memwb_d;

  dff #(.WIDTH(MEMWB_W)) u_memwb_q (
    .clk (clk_i),
    .rst (rst_i),
    .d   (memwb_vec_d),
    .q   (memwb_vec_q)
  );

  assign q_o = memwb_t'(memwb_vec_q);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-memory accesses, stalls the pipe until
// completion, resolves jump/branch redirects and loads the MEM/WB registers.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluResIn,
  input  logic [DATA_W-1:0] memWriteDataIn,
  input  logic [DATA_W-1:0] brAddrIn,
  input  logic [DATA_W-1:0] jumpAddrIn,
  input  logic [REG_W-1:0]  writeRegIn,
  input  logic              writeRegValidIn,
  input  logic              branchTakeIn,
  input  logic              JumpIn,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic              HaltIn,
  input  logic              MemToRegIn,
  input  logic              RegWriteIn,
  output logic              memReq,
  output logic              memWr,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memDone,
  output logic              stallMem,
  output logic              redirectValid,
  output logic [DATA_W-1:0] redirectAddr,
  output logic              flushOut,
  output logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] aluResOut,
  output logic [REG_W-1:0]  writeRegOut,
  output logic              MemToRegOut,
  output logic              RegWriteOut,
  output logic              writeRegValidOut,
  output logic              HaltOut,
  output logic              errOut,
  output logic [DATA_W-1:0] stallCount
);

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] stall_cnt_q, stall_cnt_d;

  logic   mem_op;
  logic   req;
  logic   stall;
  logic   complete;
  memwb_t memwb_d;
  memwb_t memwb_q;

  assign mem_op = MemReadIn | MemWriteIn;

  // Reset masks every handshake/control output so an abandoned access never leaks.
  always_comb begin
    req      = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          req      = mem_op;
          stall    = mem_op & ~memDone;
          complete = ~stall;
        end
        ST_WAIT: begin
          req      = 1'b1;
          stall    = ~memDone;
          complete = memDone;
        end
        default: begin
          req      = 1'b0;
          stall    = 1'b0;
          complete = 1'b0;
        end
      endcase
    end
  end

  assign memReq        = req;
  assign memWr         = req & MemWriteIn;
  assign memAddr       = aluResIn;
  assign memWData      = memWriteDataIn;
  assign stallMem      = stall;
  assign redirectValid = complete & (JumpIn | branchTakeIn);
  assign redirectAddr  = JumpIn ? jumpAddrIn : brAddrIn;
  assign flushOut      = redirectValid;

  always_comb begin
    state_d = state_q;
    if (stall) begin
      state_d = ST_WAIT;
    end else if (complete) begin
      state_d = HaltIn ? ST_HALTED : ST_IDLE;
    end

    err_d = err_q | ((state_q != ST_HALTED) & MemReadIn & MemWriteIn);

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign errOut     = err_q;
  assign stallCount = stall_cnt_q;

  always_comb begin
    memwb_d                 = MEMWB_BUBBLE;
    memwb_d.mem_data        = MemReadIn ? memRData : '0;
    memwb_d.alu_res         = aluResIn;
    memwb_d.write_reg       = writeRegIn;
    memwb_d.mem_to_reg      = MemToRegIn;
    memwb_d.reg_write       = RegWriteIn;
    memwb_d.write_reg_valid = writeRegValidIn;
    memwb_d.halt            = HaltIn;
  end

  memwb_reg u_memwb_reg (
    .clk_i    (clk),
    .rst_i    (rst),
    .bubble_i (~complete),
    .d_i      (memwb_d),
    .q_o      (memwb_q)
  );

  assign memDataOut       = memwb_q.mem_data;
  assign aluResOut        = memwb_q.alu_res;
  assign writeRegOut      = memwb_q.write_reg;
  assign MemToRegOut      = memwb_q.mem_to_reg;
  assign RegWriteOut      = memwb_q.reg_write;
  assign writeRegValidOut = memwb_q.write_reg_valid;
  assign HaltOut          = memwb_q.halt;

endmodule
